fast_moment_engine: RTL

Parametrised intensity-centroid moment engine for the ORB keypoint path, successor to the two-lane fixed-width FAST moment unit. Accepts a keypoint start per patch, scans a (2R+1)x(2R+1) pixel patch streamed by the line buffer, and accumulates signed first-order moments m10 = sum(x*I) and m01 = sum(y*I) for CH lanes in lockstep. Sits between the FAST detector/patch fetcher and the orientation (atan) stage. Also maintains a saturating keypoint counter.

---
 rtl/orb_pkg.sv | 84 ++++++++
 rtl/fast_moment_lane.sv | 84 ++++++++
 rtl/fast_moment_engine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/orb_pkg.sv
// Shared definitions for the ORB intensity-centroid moment path.
// Holds the FSM state encoding, the accumulator/coordinate width helpers and
// the circular-patch row-width table (umax) used when the macro
// FAST_MOMENT_CIRC_MASK_EN is defined.
package orb_pkg;

    // FSM state type and encodings
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_SCAN = 2'd1;
    localparam fsm_state_t ST_HOLD = 2'd2;

    // Signed moment accumulator width: pixel * |coord| * pixel count, plus sign
    function automatic int acc_width(input int pix_w, input int r);
        return pix_w + $clog2(r + 1) + $clog2((2 * r + 1) * (2 * r + 1)) + 1;
    endfunction

    // Signed width able to hold -R..R
    function automatic int coord_width(input int r);
        return $clog2(r + 1) + 1;
    endfunction

    // Reference row half-widths for the standard ORB radius of 15
    function automatic int umax_r15(input int v);
        case (v)
            0, 1, 2, 3: return 15;
            4, 5, 6:    return 14;
            7, 8:       return 13;
            9:          return 12;
            10:         return 11;
            11:         return 10;
            12:         return 9;
            13:         return 8;
            14:         return 6;
            15:         return 3;
            default:    return 0;
        endcase
    endfunction

    // Integer round(sqrt(n)): largest k with (2k-1)^2 <= 4n
    function automatic int round_sqrt(input int n);
        int k;
        k = 0;
        while ((2 * (k + 1) - 1) * (2 * (k + 1) - 1) <= 4 * n)
            k = k + 1;
        return k;
    endfunction

    // Generic ORB umax construction: direct rows up to vmax, then the
    // symmetric fill from the top so the octants match exactly.
    function automatic int umax_gen(input int r, input int v);
        int u [0:255];
        int vmax;
        int vmin;
        int v0;
        for (int i = 0; i < 256; i++)
            u[i] = 0;
        vmax = 0;
        while (2 * (vmax + 1) * (vmax + 1) <= r * r)
            vmax = vmax + 1;
        vmax = vmax + 1;
        vmin = 0;
        while (2 * vmin * vmin < r * r)
            vmin = vmin + 1;
        for (int i = 0; i <= vmax; i++)
            u[i] = round_sqrt(r * r - i * i);
        v0 = 0;
        for (int i = r; i >= vmin; i--) begin
            while (u[v0] == u[v0 + 1])
                v0 = v0 + 1;
            u[i] = v0;
            v0 = v0 + 1;
        end
        return u[v];
    endfunction

    // Table lookup for the reference radius, generator otherwise
    function automatic int umax_of(input int r, input int v);
        if (r == 15)
            return umax_r15(v);
        return umax_gen(r, v);
    endfunction

endpackage

// File: rtl/fast_moment_lane.sv
// One lane of the moment engine: mask test, x*I / y*I multiply and the two
// signed accumulators. With FAST_MOMENT_CIRC_MASK_EN defined only pixels
// inside the ORB circular patch contribute; otherwise the full square does.
module fast_moment_lane
    import orb_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int R     = 15,
    parameter int ACC_W = 23,
    parameter int CW    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [CW-1:0]    x,
    input  logic signed [CW-1:0]    y,
    input  logic [PIX_W-1:0]        pix,
    output logic signed [ACC_W-1:0] m10,
    output logic signed [ACC_W-1:0] m01
);

    localparam int PW = CW + PIX_W + 1;

    logic signed [PIX_W:0]     pix_s;
    logic signed [PW-1:0]      prod10;
    logic signed [PW-1:0]      prod01;
    logic                      in_mask;
    logic signed [ACC_W-1:0]   acc10_reg;
    logic signed [ACC_W-1:0]   acc01_reg;
    logic signed [ACC_W-1:0]   acc10_next;
    logic signed [ACC_W-1:0]   acc01_next;

    // Pixels are unsigned; a zero top bit makes them safe signed operands
    assign pix_s  = {1'b0, pix};
    assign prod10 = PW'(x) * PW'(pix_s);
    assign prod01 = PW'(y) * PW'(pix_s);

`ifdef FAST_MOMENT_CIRC_MASK_EN
    logic signed [CW-1:0] neg_x;
    logic signed [CW-1:0] neg_y;
    logic [CW-2:0]        abs_x;
    logic [CW-2:0]        abs_y;
    logic [CW-2:0]        umax_tab [0:R];

    // Constant row half-width table, one entry per |y|
    for (genvar gi = 0; gi <= R; gi++) begin : g_umax
        assign umax_tab[gi] = (CW-1)'(umax_of(R, gi));
    end

    assign neg_x   = -x;
    assign neg_y   = -y;
    assign abs_x   = x[CW-1] ? neg_x[CW-2:0] : x[CW-2:0];
    assign abs_y   = y[CW-1] ? neg_y[CW-2:0] : y[CW-2:0];
    assign in_mask = (abs_x <= umax_tab[abs_y]);
`else
    assign in_mask = 1'b1;
`endif

    // Accumulate only accepted, in-mask beats
    always_comb begin
        acc10_next = acc10_reg;
        acc01_next = acc01_reg;
        if (en && in_mask) begin
            acc10_next = acc10_reg + ACC_W'(prod10);
            acc01_next = acc01_reg + ACC_W'(prod01);
        end
    end

    // Accumulator registers, cleared on reset and at the start of each patch
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc10_reg <= '0;
            acc01_reg <= '0;
        end else begin
            acc10_reg <= acc10_next;
            acc01_reg <= acc01_next;
        end
    end

    assign m10 = acc10_reg;
    assign m01 = acc01_reg;

endmodule

// File: rtl/fast_moment_engine.sv
// Intensity-centroid moment engine: scans a (2R+1)^2 patch per keypoint on
// CH lockstep lanes and emits signed m10/m01 plus the captured coordinates.
// Optional macro FAST_MOMENT_CIRC_MASK_EN restricts sums to the ORB circle.
module fast_moment_engine
    import orb_pkg::*;
#(
    parameter int  CH    = 2,
    parameter int  PIX_W = 8,
    parameter int  R     = 15,
    parameter int  XY_W  = 20,
    parameter int  NUM_W = 14,
    localparam int ACC_W = acc_width(PIX_W, R)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CH*XY_W-1:0]    kp_xy,
    output logic                  busy,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [CH*PIX_W-1:0]   pix_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*XY_W-1:0]    out_xy,
    output logic [CH*ACC_W-1:0]   m10,
    output logic [CH*ACC_W-1:0]   m01,
    output logic [NUM_W-1:0]      num_kp
);

    localparam int CW = coord_width(R);
    localparam logic signed [CW-1:0] C_MIN = CW'(-R);
    localparam logic signed [CW-1:0] C_MAX = CW'(R);
    localparam logic signed [CW-1:0] C_ONE = CW'(1);

    fsm_state_t            state_reg;
    fsm_state_t            state_next;
    logic signed [CW-1:0]  x_reg;
    logic signed [CW-1:0]  y_reg;
    logic [CH*XY_W-1:0]    xy_reg;
    logic [NUM_W-1:0]      num_reg;
    logic                  accept_start;
    logic                  beat;
    logic                  last_beat;
    logic                  handshake;

    assign accept_start = (state_reg == ST_IDLE) && start;
    assign beat         = (state_reg == ST_SCAN) && pix_valid;
    assign last_beat    = beat && (x_reg == C_MAX) && (y_reg == C_MAX);
    assign handshake    = (state_reg == ST_HOLD) && out_ready;

    // Next-state logic for the IDLE -> SCAN -> HOLD cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start)     state_next = ST_SCAN;
            ST_SCAN: if (last_beat) state_next = ST_HOLD;
            ST_HOLD: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // Raster position: x inner, y outer, both starting at -R
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (accept_start) begin
            x_reg <= C_MIN;
            y_reg <= C_MIN;
        end else if (beat) begin
            if (x_reg == C_MAX) begin
                x_reg <= C_MIN;
                y_reg <= y_reg + C_ONE;
            end else begin
                x_reg <= x_reg + C_ONE;
            end
        end
    end

    // Keypoint coordinates are latched only when a start is taken
    always_ff @(posedge clk) begin
        if (rst)
            xy_reg <= '0;
        else if (accept_start)
            xy_reg <= kp_xy;
    end

    // Completed-keypoint counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            num_reg <= '0;
        else if (handshake && (num_reg != {NUM_W{1'b1}}))
            num_reg <= num_reg + 1'b1;
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        fast_moment_lane #(
            .PIX_W (PIX_W),
            .R     (R),
            .ACC_W (ACC_W),
            .CW    (CW)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (accept_start),
            .en  (beat),
            .x   (x_reg),
            .y   (y_reg),
            .pix (pix_data[gi*PIX_W +: PIX_W]),
            .m10 (m10[gi*ACC_W +: ACC_W]),
            .m01 (m01[gi*ACC_W +: ACC_W])
        );
    end

    assign busy      = (state_reg != ST_IDLE);
    assign pix_ready = (state_reg == ST_SCAN);
    assign out_valid = (state_reg == ST_HOLD);
    assign out_xy    = xy_reg;
    assign num_kp    = num_reg;

endmodule
